axi4_chan_slice: RTL

- Parametrised, channel-generic AXI4 pipeline/buffer stage. One instance sits on one of the five AXI4 channels (AW, W, B, AR, R) between a master-side port and a slave-side port.
- The channel payload (ID, ADDR, DATA, STRB, USER, LAST, ...) is carried as one packed vector of width PAYLOAD_W, so widths are no longer fixed at 1024/64/32 bits.
- MODE selects one of four forms: bypass, forward register, full skid register, or a DEPTH-entry FIFO. This breaks timing paths and absorbs burst backpressure in the interconnect.

---
 rtl/axi4_chan_slice.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/axi4_chan_slice.sv
// rtl/axi4_chan_slice.sv - channel-generic AXI4 register slice: bypass, forward, skid or FIFO
module axi4_chan_slice #(
  parameter int PAYLOAD_W = 64,
  parameter int MODE      = 2,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 S_VALID,
  output logic                 S_READY,
  input  logic [PAYLOAD_W-1:0] S_PAYLOAD,
  output logic                 M_VALID,
  input  logic                 M_READY,
  output logic [PAYLOAD_W-1:0] M_PAYLOAD,
  output logic [CNT_W-1:0]     OCCUPANCY
);

  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("axi4_chan_slice: MODE must be 0..3");
  end
  if (MODE == 3 && (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("axi4_chan_slice: DEPTH must be a power of 2 and at least 2");
  end
  if (PAYLOAD_W < 1) begin : g_bad_width
    $error("axi4_chan_slice: PAYLOAD_W must be at least 1");
  end

  if (MODE == 0) begin : g_bypass
    assign M_VALID   = S_VALID;
    assign M_PAYLOAD = S_PAYLOAD;
    assign S_READY   = M_READY;
    assign OCCUPANCY = '0;

  end else if (MODE == 1) begin : g_fwd
    logic                 vld_q;
    logic [PAYLOAD_W-1:0] data_q;
    logic                 rdy;

    assign rdy = !vld_q || M_READY;

    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        vld_q  <= 1'b0;
        data_q <= '0;
      end else if (S_VALID && rdy) begin
        vld_q  <= 1'b1;
        data_q <= S_PAYLOAD;
      end else if (M_READY) begin
        vld_q  <= 1'b0;
      end
    end

    // Outputs are forced idle for the whole reset assertion, not just after the first edge.
    assign S_READY   = rdy && !ARESET;
    assign M_VALID   = vld_q && !ARESET;
    assign M_PAYLOAD = data_q;
    assign OCCUPANCY = ARESET ? '0 : CNT_W'(vld_q);

  end else if (MODE == 2) begin : g_skid
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_state_t;

    skid_state_t          state_q;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;
    logic                 vld_q;
    logic                 rdy_q;
    logic [1:0]           occ_q;
    logic                 s_xfer;
    logic                 m_xfer;

    assign s_xfer = S_VALID && rdy_q;
    assign m_xfer = vld_q && M_READY;

    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        state_q <= ST_EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        vld_q   <= 1'b0;
        rdy_q   <= 1'b1;
        occ_q   <= 2'd0;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (s_xfer) begin
              main_q  <= S_PAYLOAD;
              vld_q   <= 1'b1;
              occ_q   <= 2'd1;
              state_q <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (s_xfer && !m_xfer) begin
              skid_q  <= S_PAYLOAD;
              rdy_q   <= 1'b0;
              occ_q   <= 2'd2;
              state_q <= ST_TWO;
            end else if (!s_xfer && m_xfer) begin
              vld_q   <= 1'b0;
              occ_q   <= 2'd0;
              state_q <= ST_EMPTY;
            end else if (s_xfer && m_xfer) begin
              main_q  <= S_PAYLOAD;
            end
          end
          ST_TWO: begin
            if (m_xfer) begin
              main_q  <= skid_q;
              rdy_q   <= 1'b1;
              occ_q   <= 2'd1;
              state_q <= ST_ONE;
            end
          end
          default: begin
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            occ_q   <= 2'd0;
            state_q <= ST_EMPTY;
          end
        endcase
      end
    end

    assign S_READY   = rdy_q && !ARESET;
    assign M_VALID   = vld_q && !ARESET;
    assign M_PAYLOAD = main_q;
    assign OCCUPANCY = ARESET ? '0 : CNT_W'(occ_q);

  end else begin : g_fifo
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PAYLOAD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_q;
    logic [PTR_W-1:0]     rd_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 push;
    logic                 pop;

    // Pop requires a stored beat, so an empty FIFO never falls through.
    assign push = S_VALID && (cnt_q != FULL);
    assign pop  = M_READY && (cnt_q != '0);

    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        if (push) begin
          mem[wr_q] <= S_PAYLOAD;
          wr_q      <= wr_q + PTR_W'(1);
        end
        if (pop) rd_q <= rd_q + PTR_W'(1);
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    assign S_READY   = (cnt_q != FULL) && !ARESET;
    assign M_VALID   = (cnt_q != '0) && !ARESET;
    assign M_PAYLOAD = mem[rd_q];
    assign OCCUPANCY = ARESET ? '0 : cnt_q;
  end

endmodule
